// File: rtl/register_file.sv
// 8x32 register file: half/full-word writeback, bypassed reads, pending-write scoreboard.
// Optional VGA debug read port enabled by defining REGFILE_DEBUG_PORT_EN.
module register_file #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int PEND_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            reg_file_write_enable,
  input  logic [ADDR_WIDTH-1:0] reg_file_register_encoding,
  input  logic [DATA_WIDTH-1:0] reg_file_writeback_data,
  input  logic [ADDR_WIDTH-1:0] read_register_encoding_1,
  input  logic [ADDR_WIDTH-1:0] read_register_encoding_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_register_encoding,
  output logic                  issue_ready,
  output logic                  source_busy_1,
  output logic                  source_busy_2,
  output logic                  scoreboard_error
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  input  logic [ADDR_WIDTH-1:0] debug_register_encoding,
  output logic [DATA_WIDTH-1:0] debug_register_data
`endif
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [PEND_WIDTH-1:0] pend_q [NUM_REGS];
  logic [PEND_WIDTH-1:0] pend_d [NUM_REGS];
  logic                  err_q;
  logic                  err_d;

  logic                  retire;
  logic                  issue_fire;
  logic [DATA_WIDTH-1:0] merged;

  assign retire = |reg_file_write_enable;

  // Stored destination word with the enabled halves replaced.
  always_comb begin
    merged = regs_q[reg_file_register_encoding];
    if (reg_file_write_enable[0])
      merged[HALF-1:0] = reg_file_writeback_data[HALF-1:0];
    if (reg_file_write_enable[1])
      merged[DATA_WIDTH-1:HALF] =
        reg_file_writeback_data[DATA_WIDTH-1:HALF];
  end

  always_comb begin
    read_data_1 = regs_q[read_register_encoding_1];
    read_data_2 = regs_q[read_register_encoding_2];
    if (retire && read_register_encoding_1 == reg_file_register_encoding)
      read_data_1 = merged;
    if (retire && read_register_encoding_2 == reg_file_register_encoding)
      read_data_2 = merged;
  end

  // Last outstanding write retiring now frees the source for decode.
  always_comb begin
    source_busy_1 = pend_q[read_register_encoding_1] != '0;
    source_busy_2 = pend_q[read_register_encoding_2] != '0;
    if (retire && read_register_encoding_1 == reg_file_register_encoding &&
        pend_q[read_register_encoding_1] == PEND_ONE)
      source_busy_1 = 1'b0;
    if (retire && read_register_encoding_2 == reg_file_register_encoding &&
        pend_q[read_register_encoding_2] == PEND_ONE)
      source_busy_2 = 1'b0;
  end

  assign issue_ready      = pend_q[issue_register_encoding] != PEND_MAX;
  assign issue_fire       = issue_valid && issue_ready;
  assign scoreboard_error = err_q;

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    err_d  = err_q;
    if (retire) begin
      regs_d[reg_file_register_encoding] = merged;
      if (pend_q[reg_file_register_encoding] == '0)
        err_d = 1'b1;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (issue_fire && issue_register_encoding == ADDR_WIDTH'(i) &&
          !(retire && reg_file_register_encoding == ADDR_WIDTH'(i)))
        pend_d[i] = pend_q[i] + PEND_ONE;
      else if (retire && reg_file_register_encoding == ADDR_WIDTH'(i) &&
               !(issue_fire && issue_register_encoding == ADDR_WIDTH'(i)) &&
               pend_q[i] != '0)
        pend_d[i] = pend_q[i] - PEND_ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
        pend_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

`ifdef REGFILE_DEBUG_PORT_EN
  logic [DATA_WIDTH-1:0] debug_q;
  logic [DATA_WIDTH-1:0] debug_d;

  assign debug_d = regs_q[debug_register_encoding];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) debug_q <= '0;
    else       debug_q <= debug_d;
  end

  assign debug_register_data = debug_q;
`endif

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed bench for register_file against a behavioural model.
// Define REGFILE_DEBUG_PORT_EN to also exercise the debug read port.
module tb_register_file;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  en    = '0;
  logic [2:0]  wd    = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  s1    = '0;
  logic [2:0]  s2    = '0;
  logic        iv    = 1'b0;
  logic [2:0]  ie    = '0;
  logic [31:0] rd1, rd2;
  logic        ready, busy1, busy2, err;
`ifdef REGFILE_DEBUG_PORT_EN
  logic [2:0]  dsel  = '0;
  logic [31:0] dbg;
`endif

  register_file dut (
    .clock                      (clock),
    .reset                      (reset),
    .reg_file_write_enable      (en),
    .reg_file_register_encoding (wd),
    .reg_file_writeback_data    (wdata),
    .read_register_encoding_1   (s1),
    .read_register_encoding_2   (s2),
    .read_data_1                (rd1),
    .read_data_2                (rd2),
    .issue_valid                (iv),
    .issue_register_encoding    (ie),
    .issue_ready                (ready),
    .source_busy_1              (busy1),
    .source_busy_2              (busy2),
    .scoreboard_error           (err)
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    .debug_register_encoding    (dsel),
    .debug_register_data        (dbg)
`endif
  );

  always #5 clock = ~clock;

  logic [31:0] mreg [8];
  int          mpend [8];
  bit          merr;
  logic [31:0] mdbg;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_rd(input logic [2:0] s);
    logic [31:0] lo, hi;
    if (en == 2'b00 || s != wd) return mreg[s];
    lo = en[0] ? (wdata & 32'h0000FFFF) : (mreg[s] & 32'h0000FFFF);
    hi = en[1] ? (wdata & 32'hFFFF0000) : (mreg[s] & 32'hFFFF0000);
    return hi | lo;
  endfunction

  function automatic logic exp_busy(input logic [2:0] s);
    if (mpend[s] == 0) return 1'b0;
    if (en != 2'b00 && wd == s && mpend[s] == 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mreg[i]  = '0;
      mpend[i] = 0;
    end
    merr = 1'b0;
    mdbg = '0;
  endtask

  task automatic model_edge();
    bit fire, ret;
    fire = iv && mpend[ie] < 3;
    ret  = en != 2'b00;
`ifdef REGFILE_DEBUG_PORT_EN
    mdbg = mreg[dsel];
`endif
    if (ret && mpend[wd] == 0) merr = 1'b1;
    if (!(fire && ret && ie == wd)) begin
      if (fire) mpend[ie]++;
      if (ret && mpend[wd] > 0) mpend[wd]--;
    end
    if (ret) mreg[wd] = exp_rd(wd);
  endtask

  task automatic check_all();
    chk("rd1", rd1, exp_rd(s1));
    chk("rd2", rd2, exp_rd(s2));
    chk("busy1", 32'(busy1), 32'(exp_busy(s1)));
    chk("busy2", 32'(busy2), 32'(exp_busy(s2)));
    chk("ready", 32'(ready), 32'(mpend[ie] < 3));
    chk("err", 32'(err), 32'(merr));
`ifdef REGFILE_DEBUG_PORT_EN
    chk("dbg", dbg, mdbg);
`endif
  endtask

  task automatic tick();
    #2;
    check_all();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle();
    en = 2'b00;
    iv = 1'b0;
  endtask

  task automatic drive(input logic [1:0] e, input logic [2:0] d,
                       input logic [31:0] v, input logic i_v,
                       input logic [2:0] i_e);
    en = e; wd = d; wdata = v; iv = i_v; ie = i_e;
  endtask

  task automatic async_reset();
    idle();
    #2 reset = 1'b1;
    #1 model_reset();
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rd1", rd1, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;

    for (int r = 0; r < 8; r++) begin
      s1 = 3'(r); s2 = 3'(7 - r); ie = 3'(r);
      tick();
    end

    s1 = 3'd3; s2 = 3'd3;
    drive(2'b11, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0);
    #2 chk("r3_bypass", rd1, 32'hDEADBEEF);
    tick();
    idle();
    #2 chk("r3_stored", rd1, 32'hDEADBEEF);
    tick();
    drive(2'b01, 3'd3, 32'h00001234, 1'b0, 3'd0);
    tick();
    drive(2'b10, 3'd3, 32'hCAFE0000, 1'b0, 3'd0);
    tick();
    idle();
    #2 chk("r3_halves", rd2, 32'hCAFE1234);
    tick();
    async_reset();

    s1 = 3'd5; s2 = 3'd5;
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, 3'd0, 32'd0, 1'b1, 3'd5);
      tick();
    end
    #2 chk("r5_full", 32'(ready), 32'd0);
    tick();
    drive(2'b11, 3'd5, 32'h55555555, 1'b0, 3'd5);
    tick();
    idle();
    #2 chk("r5_ready", 32'(ready), 32'd1);
    chk("r5_busy", 32'(busy1), 32'd1);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(2'b11, 3'd5, 32'h5A5A0000 + 32'(k), 1'b0, 3'd5);
      tick();
    end
    idle();
    #2 chk("r5_free", 32'(busy2), 32'd0);
    tick();

    s1 = 3'd2; s2 = 3'd5;
    drive(2'b00, 3'd0, 32'd0, 1'b1, 3'd2);
    tick();
    drive(2'b11, 3'd2, 32'h22223333, 1'b0, 3'd2);
    #2 chk("r2_busy_byp", 32'(busy1), 32'd0);
    chk("r2_data_byp", rd1, 32'h22223333);
    tick();
    drive(2'b00, 3'd0, 32'd0, 1'b1, 3'd2);
    tick();
    drive(2'b11, 3'd2, 32'h12345678, 1'b1, 3'd2);
    tick();
    idle();
    #2 chk("r2_pend_kept", 32'(busy1), 32'd1);
    tick();
    drive(2'b01, 3'd2, 32'h0000ABCD, 1'b0, 3'd2);
    tick();

    drive(2'b11, 3'd6, 32'h66666666, 1'b0, 3'd0);
    tick();
    idle();
    #2 chk("r6_err", 32'(err), 32'd1);
    tick();
    drive(2'b00, 3'd0, 32'd0, 1'b1, 3'd1);
    tick();
    drive(2'b11, 3'd1, 32'h11111111, 1'b0, 3'd1);
    tick();
    idle();
    #2 chk("err_sticky", 32'(err), 32'd1);
    tick();
    s1 = 3'd6;
    async_reset();
    tick();

`ifdef REGFILE_DEBUG_PORT_EN
    dsel = 3'd0;
    drive(2'b00, 3'd0, 32'd0, 1'b1, 3'd7);
    tick();
    drive(2'b11, 3'd7, 32'h0000ABCD, 1'b1, 3'd7);
    tick();
    idle();
    dsel = 3'd7;
    tick();
    #2 chk("dbg_r7", dbg, 32'h0000ABCD);
    drive(2'b11, 3'd7, 32'h77770000, 1'b0, 3'd7);
    tick();
    idle();
    #2 chk("dbg_no_byp", dbg, 32'h0000ABCD);
    tick();
    #2 chk("dbg_new", dbg, 32'h77770000);
    tick();
`endif

    async_reset();
    for (int c = 0; c < 400; c++) begin
      wd    = 3'($urandom_range(0, 7));
      en    = (mpend[wd] > 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      wdata = $urandom;
      iv    = 1'($urandom_range(0, 1));
      ie    = 3'($urandom_range(0, 7));
      s1    = ($urandom_range(0, 2) == 0) ? wd : 3'($urandom_range(0, 7));
      s2    = ($urandom_range(0, 2) == 0) ? wd : 3'($urandom_range(0, 7));
`ifdef REGFILE_DEBUG_PORT_EN
      dsel  = 3'($urandom_range(0, 7));
`endif
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
